// File: rtl/ram_arb_pkg.sv
// Shared widths and types for the arbitrated single-port RAM front end.
package ram_arb_pkg;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } reqId_e;

  // Read-return tag carried alongside each RAM access.
  typedef struct packed {
    logic   valid;
    reqId_e id;
  } tag_t;

endpackage

// File: rtl/ram_sp_arb_init_32768x4_rr_arb2.sv
// Two-way round-robin arbiter: combinational grants, registered priority pointer.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic reqA,
  input  logic reqB,
  output logic gntA_c,
  output logic gntB_c
);

  reqId_e ptr;

  // Lone requester wins; on contention the pointer decides.
  always_comb begin
    gntA_c = 1'b0;
    gntB_c = 1'b0;
    if (en) begin
      if (reqA && (!reqB || ptr == REQ_A)) begin
        gntA_c = 1'b1;
      end else if (reqB) begin
        gntB_c = 1'b1;
      end
    end
  end

  // Pointer hands priority to the requester that was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= REQ_A;
    end else if (gntA_c) begin
      ptr <= REQ_B;
    end else if (gntB_c) begin
      ptr <= REQ_A;
    end
  end

endmodule

// File: rtl/ram_sp_arb_init_32768x4.sv
// Two-requester front end for a single-port RAM with a post-reset clear sweep.
module ram_sp_arb_init_32768x4 #(
  parameter int unsigned      ADDR_W   = ram_arb_pkg::ADDR_W,
  parameter int unsigned      DATA_W   = ram_arb_pkg::DATA_W,
  parameter bit               INIT_EN  = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_dout,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_dout,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              init_busy
);

  import ram_arb_pkg::*;

  state_e            state, stateNxt;
  logic [ADDR_W-1:0] cnt, cntNxt;
  logic              ramEnNxt, ramWeNxt;
  logic [ADDR_W-1:0] ramAddrNxt;
  logic [DATA_W-1:0] ramDinNxt;
  tag_t              tag1, tag1Nxt, tag2;

  assign init_busy = (state == INIT);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state == RUN),
    .reqA   (a_req),
    .reqB   (b_req),
    .gntA_c (a_gnt),
    .gntB_c (b_gnt)
  );

  // Next state, clear-sweep counter and the RAM command for the next cycle.
  always_comb begin
    stateNxt   = state;
    cntNxt     = cnt;
    ramEnNxt   = 1'b0;
    ramWeNxt   = 1'b0;
    ramAddrNxt = ram_addr;
    ramDinNxt  = ram_din;
    tag1Nxt    = '0;
    case (state)
      INIT: begin
        ramEnNxt   = 1'b1;
        ramWeNxt   = 1'b1;
        ramAddrNxt = cnt;
        ramDinNxt  = INIT_VAL;
        cntNxt     = cnt + ADDR_W'(1);
        if (cnt == {ADDR_W{1'b1}}) begin
          stateNxt = RUN;
        end
      end
      RUN: begin
        if (a_gnt) begin
          ramEnNxt      = 1'b1;
          ramWeNxt      = a_we;
          ramAddrNxt    = a_addr;
          ramDinNxt     = a_din;
          tag1Nxt.valid = !a_we;
          tag1Nxt.id    = REQ_A;
        end else if (b_gnt) begin
          ramEnNxt      = 1'b1;
          ramWeNxt      = b_we;
          ramAddrNxt    = b_addr;
          ramDinNxt     = b_din;
          tag1Nxt.valid = !b_we;
          tag1Nxt.id    = REQ_B;
        end
      end
      default: stateNxt = RUN;
    endcase
  end

  // FSM state and sweep counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_EN ? INIT : RUN;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  // RAM command register and read-return tag pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      tag1     <= '0;
      tag2     <= '0;
    end else begin
      ram_en   <= ramEnNxt;
      ram_we   <= ramWeNxt;
      ram_addr <= ramAddrNxt;
      ram_din  <= ramDinNxt;
      tag1     <= tag1Nxt;
      tag2     <= tag1;
    end
  end

  // Route the registered RAM read data to the requester named by the tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_dout   <= '0;
      b_dout   <= '0;
    end else begin
      a_rvalid <= tag2.valid && (tag2.id == REQ_A);
      b_rvalid <= tag2.valid && (tag2.id == REQ_B);
      if (tag2.valid && tag2.id == REQ_A) begin
        a_dout <= ram_dout;
      end
      if (tag2.valid && tag2.id == REQ_B) begin
        b_dout <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_ram_sp_arb_init_32768x4.sv
// Directed bench: clear sweep, arbitration, read latency/routing, reset recovery.
module tb_ram_sp_arb_init_32768x4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [14:0] a_addr, b_addr;
  logic [3:0]  a_din, b_din;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [3:0]  a_dout, b_dout;
  logic        ram_en, ram_we;
  logic [14:0] ram_addr;
  logic [3:0]  ram_din, ram_dout;
  logic        init_busy;

  logic [3:0]  mem [0:32767];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_sp_arb_init_32768x4 #(.INIT_EN(1'b1), .INIT_VAL(4'h5)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_dout(a_dout),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_dout(b_dout),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .init_busy(init_busy)
  );

  // Single-port RAM model with registered read data.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests at the falling edge, then settle.
  task automatic step(input logic ar, input logic aw, input logic [14:0] aa, input logic [3:0] ad,
                      input logic br, input logic bw, input logic [14:0] ba, input logic [3:0] bd);
    @(negedge clk);
    a_req = ar; a_we = aw; a_addr = aa; a_din = ad;
    b_req = br; b_we = bw; b_addr = ba; b_din = bd;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 15'h0, 4'h0, 1'b0, 1'b0, 15'h0, 4'h0);
  endtask

  initial begin
    int sweepErr;
    int busyCnt;
    int gntInInit;
    int flightErr;

    rst_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
    repeat (3) @(negedge clk);

    // Reset values.
    checkVal("rst_ram_en", 32'(ram_en), 32'd0);
    checkVal("rst_ram_we", 32'(ram_we), 32'd0);
    checkVal("rst_ram_addr", 32'(ram_addr), 32'd0);
    checkVal("rst_ram_din", 32'(ram_din), 32'd0);
    checkVal("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    checkVal("rst_dout", 32'({a_dout, b_dout}), 32'd0);
    checkVal("rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
    checkVal("rst_init_busy", 32'(init_busy), 32'd1);

    // Release reset; hold an A read pending through the whole sweep.
    rst_n = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'h1234;
    sweepErr = 0; busyCnt = 1; gntInInit = 0;
    for (int i = 0; i < 32768; i++) begin
      @(negedge clk);
      #1;
      if (ram_addr !== 15'(i) || ram_en !== 1'b1 || ram_we !== 1'b1 || ram_din !== 4'h5)
        sweepErr++;
      if (init_busy) busyCnt++;
      if (i < 32767 && (a_gnt || b_gnt)) gntInInit++;
    end
    checkVal("sweep", 32'(sweepErr), 32'd0);
    checkVal("busy_cycles", 32'(busyCnt), 32'd32768);
    checkVal("gnt_in_init", 32'(gntInInit), 32'd0);
    checkVal("gnt_after_init", 32'(a_gnt), 32'd1);

    // Pending read of a cleared address returns INIT_VAL three cycles later.
    idle();
    checkVal("pend_rv_c1", 32'(a_rvalid), 32'd0);
    idle();
    idle();
    checkVal("pend_rv_c3", 32'(a_rvalid), 32'd1);
    checkVal("pend_dout", 32'(a_dout), 32'h5);
    idle();

    // A writes 1234=A then reads it back.
    step(1'b1, 1'b1, 15'h1234, 4'hA, 1'b0, 1'b0, 15'h0, 4'h0);
    checkVal("wr_gnt", 32'({a_gnt, b_gnt}), 32'b10);
    step(1'b1, 1'b0, 15'h1234, 4'h0, 1'b0, 1'b0, 15'h0, 4'h0);
    checkVal("rd_gnt", 32'({a_gnt, b_gnt}), 32'b10);
    checkVal("wr_cmd", 32'({ram_en, ram_we, ram_addr, ram_din}), 32'({2'b11, 15'h1234, 4'hA}));
    idle();
    checkVal("rd_cmd", 32'({ram_en, ram_we, ram_addr}), 32'({2'b10, 15'h1234}));
    idle();
    checkVal("no_access", 32'({ram_en, ram_we}), 32'd0);
    checkVal("rd_rv_early", 32'({a_rvalid, b_rvalid}), 32'd0);
    idle();
    checkVal("rd_rv", 32'({a_rvalid, b_rvalid}), 32'b10);
    checkVal("rd_dout", 32'(a_dout), 32'hA);
    idle();
    checkVal("wr_no_rv", 32'({a_rvalid, b_rvalid}), 32'd0);

    // B writes 0555=3 so the pointer returns to A.
    step(1'b0, 1'b0, 15'h0, 4'h0, 1'b1, 1'b1, 15'h0555, 4'h3);
    checkVal("bwr_gnt", 32'({a_gnt, b_gnt}), 32'b01);
    idle(); idle(); idle();

    // Both request reads for 8 cycles: grants alternate, data routed by tag.
    for (int c = 0; c < 12; c++) begin
      if (c < 8) step(1'b1, 1'b0, 15'h1234, 4'h0, 1'b1, 1'b0, 15'h0555, 4'h0);
      else       idle();
      checkVal($sformatf("rr_gnt_c%0d", c), 32'({a_gnt, b_gnt}),
               (c < 8) ? ((c % 2 == 0) ? 32'b10 : 32'b01) : 32'b00);
      checkVal($sformatf("rr_rv_c%0d", c), 32'({a_rvalid, b_rvalid}),
               (c >= 3 && c <= 9 && c % 2 == 1) ? 32'b10 :
               (c >= 4 && c <= 10 && c % 2 == 0) ? 32'b01 : 32'b00);
      if (c >= 3 && c <= 9 && c % 2 == 1) checkVal($sformatf("rr_adout_c%0d", c), 32'(a_dout), 32'hA);
      if (c >= 4 && c <= 10 && c % 2 == 0) checkVal($sformatf("rr_bdout_c%0d", c), 32'(b_dout), 32'h3);
    end

    // A wins a contention; B abandons its write without a grant.
    step(1'b1, 1'b0, 15'h0000, 4'h0, 1'b1, 1'b1, 15'h0002, 4'h7);
    checkVal("drop_gnt", 32'({a_gnt, b_gnt}), 32'b10);
    idle();
    checkVal("drop_cmd", 32'({ram_en, ram_we, ram_addr}), 32'({2'b10, 15'h0000}));
    idle();
    checkVal("drop_nothing", 32'({ram_en, ram_we}), 32'd0);
    idle();
    checkVal("a0_rv", 32'({a_rvalid, b_rvalid}), 32'b10);
    checkVal("a0_dout", 32'(a_dout), 32'h5);
    step(1'b0, 1'b0, 15'h0, 4'h0, 1'b1, 1'b0, 15'h0002, 4'h0);
    checkVal("b2_gnt", 32'({a_gnt, b_gnt}), 32'b01);
    idle(); idle(); idle();
    checkVal("b2_rv", 32'({a_rvalid, b_rvalid}), 32'b01);
    checkVal("b2_dout", 32'(b_dout), 32'h5);

    // Two reads in flight, then reset.
    step(1'b1, 1'b0, 15'h1234, 4'h0, 1'b1, 1'b0, 15'h0555, 4'h0);
    checkVal("fl_gnt0", 32'({a_gnt, b_gnt}), 32'b10);
    step(1'b0, 1'b0, 15'h0, 4'h0, 1'b1, 1'b0, 15'h0555, 4'h0);
    checkVal("fl_gnt1", 32'({a_gnt, b_gnt}), 32'b01);
    @(negedge clk);
    b_req = 1'b0;
    rst_n = 1'b0;
    #1;
    checkVal("fl_rst_en", 32'({ram_en, ram_we}), 32'd0);
    checkVal("fl_rst_busy", 32'(init_busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    flightErr = 0;
    sweepErr = 0;
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      #1;
      if (a_rvalid || b_rvalid) flightErr++;
      if (ram_addr !== 15'(k) || ram_en !== 1'b1) sweepErr++;
    end
    checkVal("fl_no_rvalid", 32'(flightErr), 32'd0);
    checkVal("fl_resweep", 32'(sweepErr), 32'd0);

    // Reset mid-sweep at address 100; sweep restarts from 0.
    rst_n = 1'b0;
    #1;
    checkVal("mid_rst_addr", 32'({ram_en, ram_addr}), 32'd0);
    checkVal("mid_rst_busy", 32'(init_busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkVal("mid_restart", 32'({ram_en, ram_we, ram_addr}), 32'({2'b11, 15'h0000}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_sp_arb_init_32768x4.md
RAM_SP_ARB_INIT_32768X4 -- requirements
Module: ram_sp_arb_init_32768x4

Interface
REQ-001 Parameter ADDR_W, 15, RAM address width (32768 words).
REQ-002 Parameter DATA_W, 4, RAM word width.
REQ-003 Parameter INIT_EN, 1, when 1 the block clears the RAM after reset.
REQ-004 Parameter INIT_VAL, 4'h0, word written to every address during clear.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset; the ports are named clk and rst_n.
REQ-006 clk  input  1  clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 a_req / b_req  input  1  requester A / B access request; held until granted.
REQ-009 a_we / b_we  input  1  1 = write, 0 = read; valid with req.
REQ-010 a_addr / b_addr  input  ADDR_W  access address.
REQ-011 a_din / b_din  input  DATA_W  write data.
REQ-012 a_gnt / b_gnt  output  1  grant; the transfer occurs in a cycle where req and gnt are both 1.
REQ-013 a_rvalid / b_rvalid  output  1  one-cycle read-data strobe.
REQ-014 a_dout / b_dout  output  DATA_W  read data; valid only while rvalid is 1.
REQ-015 ram_en, ram_we  output  1  single-port RAM enable and write enable.
REQ-016 ram_addr  output  ADDR_W  RAM address.
REQ-017 ram_din  output  DATA_W  RAM write data.
REQ-018 ram_dout  input  DATA_W  RAM read data; registered, valid the cycle after an en=1, we=0 access.
REQ-019 init_busy  output  1  clear sweep in progress.

Function
REQ-020 The FSM SHALL have two states: INIT and RUN. It enters INIT after reset when INIT_EN=1, and RUN otherwise.
REQ-021 INIT: each cycle drive ram_en=1, ram_we=1, ram_din=INIT_VAL and ram_addr=counter; the counter runs 0..32767, one step per cycle.
REQ-022 INIT ends after writing address 32767 (32768 write cycles); the FSM then moves to RUN and the counter wraps to 0.
REQ-023 In INIT, init_busy=1 and a_gnt=b_gnt=0; requests stay pending.
REQ-024 RUN: at most one gnt per cycle. Grants are combinational from req and the priority pointer.
REQ-025 Arbitration SHALL be round-robin: if only one requester asserts req, it is granted. If both assert req, the requester named by the pointer is granted. After each grant, the pointer moves to the other requester.
REQ-026 A handshake in cycle T drives ram_en=1, ram_we, ram_addr and ram_din from the granted requester, registered, in cycle T+1.
REQ-027 In cycles with no access, ram_en=0 and ram_we=0.
REQ-028 For a read handshaken in cycle T, the requester's rvalid=1 and dout=ram_dout, registered, in cycle T+3. Fixed latency is 3 cycles.
REQ-029 Writes produce no rvalid.
REQ-030 The pipeline SHALL accept back-to-back handshakes every cycle. A 2-stage tag pipeline {valid, requester id} routes read data to the correct requester.
REQ-031 RAM accesses SHALL be issued in grant order, so a read granted after a write to the same address returns the new data.
REQ-032 A requester that drops req without a grant is allowed; nothing is issued for it.

Reset
REQ-033 Asserting rst_n=0 at any time, including mid-INIT or with reads in flight, SHALL immediately clear the pipeline and tags, drop pending rvalids, reset the pointer to A, and zero the counter.
REQ-034 Reset values: gnt=0, rvalid=0, dout=0, ram_en=0, ram_we=0, ram_addr=0, ram_din=0, init_busy=INIT_EN.
REQ-035 After rst_n rises, INIT starts writing address 0 on the first clock edge.

Structure
REQ-036 Package ram_arb_pkg SHALL hold ADDR_W, DATA_W, the state enum {INIT, RUN} and the requester-id type.
REQ-037 Sub-module rr_arb2 SHALL implement the 2-way round-robin grant and its pointer; everything else stays in the top module.

Verification
REQ-038 Reset release, INIT_EN=1 -> init_busy=1 for exactly 32768 cycles; ram_addr sweeps 0..32767 with ram_we=1 and ram_din=0; then gnt is possible.
REQ-039 A writes 15'h1234=4'hA in cycle T; A reads 15'h1234 in T+1 -> a_rvalid=1 and a_dout=4'hA in T+4; b_rvalid stays 0.
REQ-040 a_req and b_req held high for 8 cycles -> grants alternate A,B,A,B...; with 8 reads, 8 rvalids arrive 3 cycles after each handshake to the matching requester.
REQ-041 Read of a never-written address after INIT with INIT_VAL=4'h5 -> dout=4'h5.
REQ-042 rst_n pulsed low with 2 reads in flight and INIT at address 100 -> no rvalid afterwards; INIT restarts at address 0.
